// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Contains the 4-bit ALU control codes ({Ainvert, Binvert, Operation}),
// the 2-bit slice operation codes, and the serial ALU FSM state encoding.
package alu_pkg;

    // Full control words, {Ainvert, Binvert, Operation[1:0]}
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Operation field as seen by the one-bit slice
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } serial_state_t;

endpackage

// File: rtl/bit_alu.sv
// One-bit ALU slice.
// Ports:
//   a, b        operand bits
//   less        value returned for operation 11 (set-on-less-than input)
//   a_invert    invert a before use
//   b_invert    invert b before use
//   carry_in    adder carry input
//   operation   00 AND, 01 OR, 10 ADD, 11 LESS
//   result      selected result bit
//   carry_out   adder carry output (valid for every operation)
module bit_alu (
    input  logic       a,
    input  logic       b,
    input  logic       less,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       carry_in,
    input  logic [1:0] operation,
    output logic       result,
    output logic       carry_out
);

    logic a_eff;
    logic b_eff;
    logic sum;

    assign a_eff     = a ^ a_invert;
    assign b_eff     = b ^ b_invert;
    assign sum       = a_eff ^ b_eff ^ carry_in;
    assign carry_out = (a_eff & b_eff) | (a_eff & carry_in) | (b_eff & carry_in);

    always_comb begin
        result = 1'b0;
        case (operation)
            2'b00:   result = a_eff & b_eff;
            2'b01:   result = a_eff | b_eff;
            2'b10:   result = sum;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: runs one bit_alu slice once per cycle, LSB first.
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   start       request; only accepted in IDLE or DONE
//   a, b        operands, captured on an accepted start
//   alu_ctrl    {Ainvert, Binvert, Operation[1:0]}
//   busy        high while bits are being processed
//   done        one-cycle completion pulse
//   result      registered final result
//   zero        result == 0, registered with result
//   overflow    signed overflow for ADD-class (Operation 10) only
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);

    serial_state_t    state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_sh_reg;
    logic [3:0]       ctrl_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;

    logic             slice_result;
    logic             slice_carry_out;
    logic [1:0]       slice_op;
    logic             last_bit;
    logic             msb_overflow;
    logic             slt_set;
    logic [WIDTH-1:0] shifted_result;
    logic [WIDTH-1:0] final_result;

    // SLT runs the slice as an adder; the less/set decision is made at completion.
    assign slice_op = (ctrl_reg[1:0] == OP_SLT) ? OP_ADD : ctrl_reg[1:0];

    bit_alu u_bit_alu (
        .a         (a_sh_reg[0]),
        .b         (b_sh_reg[0]),
        .less      (1'b0),
        .a_invert  (ctrl_reg[3]),
        .b_invert  (ctrl_reg[2]),
        .carry_in  (carry_reg),
        .operation (slice_op),
        .result    (slice_result),
        .carry_out (slice_carry_out)
    );

    // On the last bit, carry_reg is the carry into the MSB and the slice
    // outputs are the MSB sum and carry out.
    assign last_bit       = (cnt_reg == CNT_W'(WIDTH - 1));
    assign msb_overflow   = carry_reg ^ slice_carry_out;
    assign slt_set        = slice_result ^ msb_overflow;
    assign shifted_result = {slice_result, res_sh_reg[WIDTH-1:1]};
    assign final_result   = (ctrl_reg[1:0] == OP_SLT)
                          ? {{(WIDTH-1){1'b0}}, slt_set}
                          : shifted_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_sh_reg <= '0;
            ctrl_reg   <= '0;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    carry_reg  <= slice_carry_out;
                    res_sh_reg <= shifted_result;
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (last_bit) begin
                        result    <= final_result;
                        zero      <= (final_result == '0);
                        overflow  <= (ctrl_reg[1:0] == OP_ADD) ? msb_overflow : 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    done <= 1'b0;
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b;
                        ctrl_reg  <= alu_ctrl;
                        cnt_reg   <= '0;
                        carry_reg <= alu_ctrl[2];   // +1 for two's-complement subtract
                        busy      <= 1'b1;
                        state_reg <= ST_RUN;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/serial_alu.md
# serial_alu

Bit-serial 32-bit ALU. It reuses the team's one-bit ALU slice (`bit_alu`) once per cycle, from LSB to MSB, instead of rippling through 32 instances. It sits beside the single-cycle datapath as a low-area execution unit for the multi-cycle CPU variant. It drives the slice's inputs (a, b, less, invert controls, carry_in, operation) and consumes its result/carry_out bit stream through a start/done handshake.

## Interface
- `WIDTH`, default 32: operand width; legal range is WIDTH ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  operand A; captured on the accepted start.
- `b`  in  WIDTH  operand B; captured on the accepted start.
- `alu_ctrl`  in  4  control word: [3] Ainvert, [2] Binvert, [1:0] Operation (00 AND, 01 OR, 10 ADD, 11 SLT).
- `busy`  out  1  high while bits are being processed.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  final result; registered.
- `zero`  out  1  result == 0; registered with result.
- `overflow`  out  1  signed overflow; ADD-class operations only.

## Operation
- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN on start.
  - RUN → DONE after WIDTH bit cycles.
  - DONE → RUN if start is high, else → IDLE.
- **Accepted start:**
  - Latch a, b and alu_ctrl into shift/ctrl registers.
  - Clear bit counter `cnt` to 0.
  - Load carry register with alu_ctrl[2] (Binvert), giving the +1 for subtract.
- **RUN cycle k (k = 0..WIDTH-1):**
  - Slice gets a_sh[0], b_sh[0], the latched invert bits, carry register and Operation.
  - If Operation = 11, the slice is driven with Operation 10 so the sum is computed; the result bit is discarded.
  - carry register ← carry_out.
  - Result bit shifts into the internal result shifter from the MSB side.
  - a_sh and b_sh shift right by one; cnt increments.
- **At k = WIDTH-1:**
  - Capture carry_in_msb (carry register before update), carry_out_msb and sum_msb.
- **Completion:**
  - overflow = carry_in_msb XOR carry_out_msb when Operation = 10; 0 otherwise.
  - SLT: set = sum_msb XOR (carry_in_msb XOR carry_out_msb), which is overflow-corrected; result = {WIDTH-1 zeros, set}.
  - Other operations: result = internal shifter contents.
  - zero = (final result == 0).
- **Output hold:** result, zero and overflow change only at completion and hold until the next completion.
- **start while RUN:** ignored; no effect on operands or progress.
- **Slice `less` input:** tied 0, because SLT is resolved at completion.
- **Reset, at any time including mid-RUN:**
  - state → IDLE; busy, done, result, zero, overflow, cnt and carry → 0.
  - Any in-flight operation is discarded.

## Timing
- Start accepted at edge T.
- busy is high for cycles T+1 … T+WIDTH.
- The completion edge is T+WIDTH.
- done is high for exactly one cycle after that edge. For WIDTH = 32 this is the 33rd cycle after the start edge.
- result, zero and overflow are valid in the done cycle and afterwards.
- Back-to-back issue: start in the DONE cycle begins the next operation with no idle cycle; throughput is one op per WIDTH+1 cycles.
- busy and done are never high together.

## Structure
- **Shared package `alu_pkg`:**
  - ALU_AND = 4'b0000
  - ALU_OR = 4'b0001
  - ALU_ADD = 4'b0010
  - ALU_SUB = 4'b0110
  - ALU_SLT = 4'b0111
  - ALU_NOR = 4'b1100
  - FSM state encoding (2 bits)
- **Sub-module:** exactly one instance of `bit_alu`, unmodified.
- All sequencing, shifters, counter and flag logic live in `serial_alu`.

## Test plan
- **ADD:** a = 7, b = 5, ctrl 0010.
  - Expect result = 12, zero = 0, overflow = 0.
  - done pulses exactly 33 cycles after the start edge; busy is high for 32 cycles.
- **SUB:** a = 0x7FFFFFFF, b = 0xFFFFFFFF, ctrl 0110.
  - Expect result = 0x80000000, overflow = 1.
- **SUB to zero:** a = 5, b = 5, ctrl 0110.
  - Expect result = 0, zero = 1, overflow = 0.
- **SLT:**
  - a = 0xFFFFFFFF, b = 1 → result = 1.
  - a = 0x7FFFFFFF, b = 0x80000000 → result = 0 (overflow-corrected); overflow output = 0.
- **NOR / AND:**
  - NOR of 0 and 0 (ctrl 1100) → 0xFFFFFFFF, zero = 0.
  - AND 0xF0F0F0F0 with 0x0F0F0F0F → 0, zero = 1.
- **Handshake and reset:**
  - A start pulse at bit 10 of a running ADD is ignored, and the first op completes correctly.
  - A start in the DONE cycle gives its result 33 cycles later.
  - rst asserted mid-RUN forces all outputs to 0 immediately (asynchronously). After release, a fresh ADD 1+1 returns 2.
